// File: rtl/dadder_dp_arb.sv
// Two-requester round-robin front end for one shared decimal (BCD) adder; one op in flight.
// Optional macro DADDER_DP_ARB_LOCK_EN adds req0_lock/req1_lock grant locking.
`timescale 1ns/1ps
module dadder_dp_arb #(
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned ADDER_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic [DATA_WIDTH-1:0] req0_op_a,
  input  logic [DATA_WIDTH-1:0] req0_op_b,
  input  logic                  req0_carry_in,
  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic [DATA_WIDTH-1:0] req1_op_a,
  input  logic [DATA_WIDTH-1:0] req1_op_b,
  input  logic                  req1_carry_in,
`ifdef DADDER_DP_ARB_LOCK_EN
  input  logic                  req0_lock,
  input  logic                  req1_lock,
`endif
  output logic [DATA_WIDTH-1:0] add_op_a,
  output logic [DATA_WIDTH-1:0] add_op_b,
  output logic                  add_carry_in,
  input  logic [DATA_WIDTH-1:0] add_result,
  input  logic                  add_carry_out,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic                  rsp_id,
  output logic [DATA_WIDTH-1:0] rsp_result,
  output logic                  rsp_carry_out
);

  localparam logic [3:0] LAT = 4'(ADDER_LATENCY);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;
  state_e state_q, state_d;

  logic                  last_grant_q;
  logic                  grant;
  logic                  any_valid;
  logic                  hs;
  logic [3:0]            cnt_q;
  logic                  fresh_q;
  logic [DATA_WIDTH-1:0] op_a_q, op_b_q, result_q;
  logic                  cin_q, cout_q, id_q;
`ifdef DADDER_DP_ARB_LOCK_EN
  logic                  lock_q, lock_id_q;
`endif

  always_comb begin
    any_valid = req0_valid | req1_valid;
    grant     = (req0_valid && req1_valid) ? ~last_grant_q : req1_valid;
`ifdef DADDER_DP_ARB_LOCK_EN
    if (lock_q && (lock_id_q ? req1_valid : req0_valid)) grant = lock_id_q;
`endif
  end

  assign hs = (state_q == S_IDLE) && any_valid;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (any_valid) state_d = (LAT == 4'd0) ? S_RESP : S_WAIT;
      S_WAIT: if (cnt_q <= 4'd1) state_d = S_RESP;
      S_RESP: if (rsp_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    rsp_valid  = 1'b0;
    if (state_q == S_IDLE && any_valid) begin
      req0_ready = ~grant;
      req1_ready = grant;
    end
    if (state_q == S_RESP) rsp_valid = 1'b1;
  end

  // Capture on the edge where the counter reaches zero so rsp_valid lands LATENCY+1 after the handshake.
  // With zero latency the first RESP cycle forwards add_result while it is being captured.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      op_a_q       <= '0;
      op_b_q       <= '0;
      cin_q        <= 1'b0;
      id_q         <= 1'b0;
      last_grant_q <= 1'b1;
      cnt_q        <= '0;
      fresh_q      <= 1'b0;
      result_q     <= '0;
      cout_q       <= 1'b0;
`ifdef DADDER_DP_ARB_LOCK_EN
      lock_q       <= 1'b0;
      lock_id_q    <= 1'b0;
`endif
    end else if (hs) begin
      op_a_q       <= grant ? req1_op_a : req0_op_a;
      op_b_q       <= grant ? req1_op_b : req0_op_b;
      cin_q        <= grant ? req1_carry_in : req0_carry_in;
      id_q         <= grant;
      last_grant_q <= grant;
      cnt_q        <= LAT;
      fresh_q      <= (LAT == 4'd0);
`ifdef DADDER_DP_ARB_LOCK_EN
      lock_q       <= grant ? req1_lock : req0_lock;
      lock_id_q    <= grant;
`endif
    end else if (state_q == S_WAIT) begin
      cnt_q <= cnt_q - 4'd1;
      if (cnt_q <= 4'd1) begin
        result_q <= add_result;
        cout_q   <= add_carry_out;
      end
    end else if (state_q == S_RESP && fresh_q) begin
      result_q <= add_result;
      cout_q   <= add_carry_out;
      fresh_q  <= 1'b0;
    end
  end

  assign add_op_a      = op_a_q;
  assign add_op_b      = op_b_q;
  assign add_carry_in  = cin_q;
  assign rsp_id        = id_q;
  assign rsp_result    = fresh_q ? add_result : result_q;
  assign rsp_carry_out = fresh_q ? add_carry_out : cout_q;

endmodule

// File: tb/tb_dadder_dp_arb.sv
// Bench for dadder_dp_arb: three instances (latency 1, 0, 3) sharing stimulus; instance 0 is the main target.
`timescale 1ns/1ps
module tb_dadder_dp_arb;
  localparam int W  = 32;
  localparam int ND = W / 4;
  localparam int NI = 3;

  logic clk, reset_n;
  logic v0, v1, c0, c1, rsp_ready;
  logic [W-1:0] a0, b0, a1, b1;
`ifdef DADDER_DP_ARB_LOCK_EN
  logic lock0, lock1;
`endif

  logic rdy0[NI], rdy1[NI], rv[NI], rid[NI], aci[NI], aco[NI], rco[NI];
  logic [W-1:0] aa[NI], ab[NI], ares[NI], rres[NI];

  int n_vec = 0;
  int n_err = 0;

  function automatic int tb_lat(int k);
    return (k == 0) ? 1 : ((k == 1) ? 0 : 3);
  endfunction

  // Decimal reference: decode both operands to integers, add, re-encode.
  function automatic logic [W:0] bcd_add(logic [W-1:0] a, logic [W-1:0] b, logic ci);
    longint unsigned sa = 0, sb = 0, s, lim = 1;
    logic [W-1:0] r = '0;
    logic co;
    for (int i = ND - 1; i >= 0; i--) begin
      sa = sa * 10 + longint'(a[4*i +: 4]);
      sb = sb * 10 + longint'(b[4*i +: 4]);
      lim = lim * 10;
    end
    s  = sa + sb + longint'(ci);
    co = (s >= lim);
    if (co) s = s - lim;
    for (int i = 0; i < ND; i++) begin
      r[4*i +: 4] = 4'(s % 10);
      s = s / 10;
    end
    return {co, r};
  endfunction

  function automatic logic [W-1:0] rand_bcd();
    logic [W-1:0] r = '0;
    for (int i = 0; i < ND; i++) r[4*i +: 4] = 4'($urandom_range(9));
    return r;
  endfunction

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int unsigned GL = (g == 0) ? 1 : ((g == 1) ? 0 : 3);
    assign {aco[g], ares[g]} = bcd_add(aa[g], ab[g], aci[g]);
    dadder_dp_arb #(.DATA_WIDTH(W), .ADDER_LATENCY(GL)) u_dut (
      .clk(clk), .reset_n(reset_n),
      .req0_valid(v0), .req0_ready(rdy0[g]), .req0_op_a(a0), .req0_op_b(b0), .req0_carry_in(c0),
      .req1_valid(v1), .req1_ready(rdy1[g]), .req1_op_a(a1), .req1_op_b(b1), .req1_carry_in(c1),
`ifdef DADDER_DP_ARB_LOCK_EN
      .req0_lock(lock0), .req1_lock(lock1),
`endif
      .add_op_a(aa[g]), .add_op_b(ab[g]), .add_carry_in(aci[g]),
      .add_result(ares[g]), .add_carry_out(aco[g]),
      .rsp_valid(rv[g]), .rsp_ready(rsp_ready), .rsp_id(rid[g]),
      .rsp_result(rres[g]), .rsp_carry_out(rco[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    v0 = 0; v1 = 0; c0 = 0; c1 = 0; rsp_ready = 0;
    a0 = '0; b0 = '0; a1 = '0; b1 = '0;
`ifdef DADDER_DP_ARB_LOCK_EN
    lock0 = 0; lock1 = 0;
`endif
  endtask

  task automatic do_reset();
    idle_inputs();
    reset_n = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst ready0", 64'(rdy0[0]), 0);
    check("rst ready1", 64'(rdy1[0]), 0);
    check("rst rsp_valid", 64'(rv[0]), 0);
    check("rst rsp_id", 64'(rid[0]), 0);
    check("rst rsp_result", 64'(rres[0]), 0);
    check("rst add_op_a", 64'(aa[0]), 0);
    check("rst add_carry_in", 64'(aci[0]), 0);
    reset_n = 1;
  endtask

  typedef struct {
    logic v0, v1;
    logic [W-1:0] a0, b0; logic c0;
    logic [W-1:0] a1, b1; logic c1;
    logic eid; logic [W-1:0] eres; logic eco;
  } vec_t;
  vec_t tbl[6];

  task automatic apply_vec(input int i);
    int lat;
    @(posedge clk); #1;
    v0 = tbl[i].v0; v1 = tbl[i].v1;
    a0 = tbl[i].a0; b0 = tbl[i].b0; c0 = tbl[i].c0;
    a1 = tbl[i].a1; b1 = tbl[i].b1; c1 = tbl[i].c1;
    rsp_ready = 0;
    @(negedge clk);
    check($sformatf("vec%0d ready0", i), 64'(rdy0[0]), 64'(!tbl[i].eid));
    check($sformatf("vec%0d ready1", i), 64'(rdy1[0]), 64'(tbl[i].eid));
    @(posedge clk); #1;
    v0 = 0; v1 = 0;
    lat = 1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (rv[0]) break;
      lat++;
    end
    check($sformatf("vec%0d latency", i), 64'(lat), 2);
    check($sformatf("vec%0d rsp_id", i), 64'(rid[0]), 64'(tbl[i].eid));
    check($sformatf("vec%0d rsp_result", i), 64'(rres[0]), 64'(tbl[i].eres));
    check($sformatf("vec%0d rsp_carry", i), 64'(rco[0]), 64'(tbl[i].eco));
    rsp_ready = 1;
    @(posedge clk); #1;
    rsp_ready = 0;
    @(negedge clk);
    check($sformatf("vec%0d rsp drop", i), 64'(rv[0]), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time exhausted, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    logic gr[4];
    logic ids[4];
    int ng, nr;
    int first[NI];
    logic mbusy, mlast, mid, mco, ev, any, w;
    logic [W-1:0] mres;
    int mdue;

    tbl[0] = '{1'b1, 1'b0, 32'h00000999, 32'h00000001, 1'b0, '0, '0, 1'b0, 1'b0, 32'h00001000, 1'b0};
    tbl[1] = '{1'b0, 1'b1, '0, '0, 1'b0, 32'h99999999, 32'h00000001, 1'b0, 1'b1, 32'h00000000, 1'b1};
    tbl[2] = '{1'b1, 1'b1, 32'h12345678, 32'h11111111, 1'b1, 32'h44444444, 32'h22222222, 1'b0,
               1'b0, 32'h23456790, 1'b0};
    tbl[3] = '{1'b1, 1'b1, 32'h00000011, 32'h00000022, 1'b0, 32'h50000000, 32'h50000000, 1'b0,
               1'b1, 32'h00000000, 1'b1};
    tbl[4] = '{1'b1, 1'b1, 32'h00000000, 32'h00000000, 1'b1, 32'h00000001, 32'h00000001, 1'b0,
               1'b0, 32'h00000001, 1'b0};
    tbl[5] = '{1'b0, 1'b1, '0, '0, 1'b0, 32'h00000009, 32'h00000009, 1'b1, 1'b1, 32'h00000019, 1'b0};

    do_reset();
    for (int i = 0; i < 6; i++) apply_vec(i);

    // Continuous contention alternates grants starting with req0.
    do_reset();
    @(posedge clk); #1;
    v0 = 1; v1 = 1; a0 = 32'h00000123; b0 = 32'h00000456; a1 = 32'h00000777; b1 = 32'h00000333;
    rsp_ready = 1;
    ng = 0; nr = 0;
    for (int k = 0; k < 4; k++) begin gr[k] = 1'bx; ids[k] = 1'bx; end
    for (int c = 0; c < 60 && nr < 4; c++) begin
      @(negedge clk);
      if (rv[0]) check("no grant during rsp", 64'(rdy0[0] | rdy1[0]), 0);
      if (ng < 4 && (rdy0[0] || rdy1[0])) begin gr[ng] = rdy1[0]; ng++; end
      if (rv[0]) begin ids[nr] = rid[0]; nr++; end
    end
    for (int k = 0; k < 4; k++) begin
      check($sformatf("rr grant%0d", k), 64'(gr[k]), 64'(k % 2));
      check($sformatf("rr rsp_id%0d", k), 64'(ids[k]), 64'(k % 2));
    end
    @(posedge clk); #1;
    v0 = 0; v1 = 0; rsp_ready = 0;
    @(posedge clk); #1;

    // Back-pressured response stays stable and blocks new grants.
    v0 = 1; a0 = 32'h00000999; b0 = 32'h00000001; c0 = 0;
    @(negedge clk);
    check("bp ready0", 64'(rdy0[0]), 1);
    @(posedge clk); #1;
    v1 = 1;
    for (int c = 0; c < 10 && !rv[0]; c++) @(negedge clk);
    for (int c = 0; c < 5; c++) begin
      check("bp rsp_valid", 64'(rv[0]), 1);
      check("bp rsp_id", 64'(rid[0]), 0);
      check("bp rsp_result", 64'(rres[0]), 64'h1000);
      check("bp ready held", 64'(rdy0[0] | rdy1[0]), 0);
      @(negedge clk);
    end
    rsp_ready = 1;
    @(posedge clk); #1;
    rsp_ready = 0;
    @(negedge clk);
    check("bp release valid", 64'(rv[0]), 0);
    check("bp release ready1", 64'(rdy1[0]), 1);
    check("bp release ready0", 64'(rdy0[0]), 0);

    // Reset mid-operation discards it and restores req0 priority.
    do_reset();
    @(posedge clk); #1;
    v0 = 1; a0 = 32'h00000005; b0 = 32'h00000005;
    @(negedge clk);
    check("rmid ready0", 64'(rdy0[0]), 1);
    @(posedge clk); #1;
    v0 = 0; reset_n = 0;
    @(posedge clk); #1;
    reset_n = 1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      check("rmid no rsp", 64'(rv[0]), 0);
    end
    @(posedge clk); #1;
    v0 = 1; v1 = 1;
    @(negedge clk);
    check("rmid contend ready0", 64'(rdy0[0]), 1);
    check("rmid contend ready1", 64'(rdy1[0]), 0);

    // Latency of all three instances measured from a common handshake.
    do_reset();
    @(posedge clk); #1;
    v0 = 1; a0 = 32'h00000045; b0 = 32'h00000055; c0 = 0; rsp_ready = 1;
    @(negedge clk);
    for (int k = 0; k < NI; k++) check($sformatf("lat%0d ready0", tb_lat(k)), 64'(rdy0[k]), 1);
    @(posedge clk); #1;
    v0 = 0;
    for (int k = 0; k < NI; k++) first[k] = -1;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      for (int k = 0; k < NI; k++) begin
        if (rv[k] && first[k] < 0) begin
          first[k] = c;
          check($sformatf("lat%0d result", tb_lat(k)), 64'(rres[k]), 64'h100);
        end
      end
    end
    for (int k = 0; k < NI; k++)
      check($sformatf("lat%0d cycles", tb_lat(k)), 64'(first[k]), 64'(tb_lat(k) + 1));

`ifdef DADDER_DP_ARB_LOCK_EN
    do_reset();
    @(posedge clk); #1;
    v0 = 1; v1 = 1; lock0 = 1; rsp_ready = 1;
    ng = 0;
    for (int k = 0; k < 4; k++) gr[k] = 1'bx;
    for (int c = 0; c < 60 && ng < 4; c++) begin
      @(negedge clk);
      if (rdy0[0] || rdy1[0]) begin
        gr[ng] = rdy1[0]; ng++;
        if (ng == 2) lock0 = 0;
      end
    end
    for (int k = 0; k < 4; k++) check($sformatf("lock grant%0d", k), 64'(gr[k]), (k == 3) ? 1 : 0);
`endif

    // Randomized traffic against a transaction-level model.
    do_reset();
    mbusy = 0; mlast = 1; mid = 0; mco = 0; mres = '0; mdue = 0;
    for (int c = 0; c < 400; c++) begin
      @(posedge clk); #1;
      v0 = 1'($urandom_range(1)); v1 = 1'($urandom_range(1));
      a0 = rand_bcd(); b0 = rand_bcd(); c0 = 1'($urandom_range(1));
      a1 = rand_bcd(); b1 = rand_bcd(); c1 = 1'($urandom_range(1));
      rsp_ready = ($urandom_range(3) != 0);
      @(negedge clk);
      ev  = mbusy && (c >= mdue);
      any = !mbusy && (v0 || v1);
      w   = (v0 && v1) ? !mlast : v1;
      check("rnd ready0", 64'(rdy0[0]), 64'(any && !w));
      check("rnd ready1", 64'(rdy1[0]), 64'(any && w));
      check("rnd rsp_valid", 64'(rv[0]), 64'(ev));
      if (ev) begin
        check("rnd rsp_id", 64'(rid[0]), 64'(mid));
        check("rnd rsp_result", 64'(rres[0]), 64'(mres));
        check("rnd rsp_carry", 64'(rco[0]), 64'(mco));
      end
      if (any) begin
        mbusy = 1; mdue = c + 2; mid = w; mlast = w;
        {mco, mres} = w ? bcd_add(a1, b1, c1) : bcd_add(a0, b0, c0);
      end else if (ev && rsp_ready) begin
        mbusy = 0;
      end
    end
    @(posedge clk); #1;
    idle_inputs();
    repeat (3) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/dadder_dp_arb.md
DADDER_DP_ARB -- requirements
Module: dadder_dp_arb

Interface
REQ-001 SHALL have one clock, clk; reset_n is asynchronous and active-low.
REQ-002 Parameter DATA_WIDTH, default 32; operand width in bits; multiple of 4 (BCD digits).
REQ-003 Parameter ADDER_LATENCY, default 1; adder cycles from operands to result; legal 0..15.
REQ-004 Ports, one per line (name, direction, width, meaning):
 clk  in  1  clock
 reset_n  in  1  async active-low reset
 reqN_valid  in  1  requester N (N=0,1) operation valid
 reqN_ready  out  1  requester N accepted
 reqN_op_a / reqN_op_b  in  DATA_WIDTH  BCD operands
 reqN_carry_in  in  1  carry in
 add_op_a / add_op_b  out  DATA_WIDTH  to shared decimal adder
 add_carry_in  out  1  to shared decimal adder
 add_result  in  DATA_WIDTH  from adder
 add_carry_out  in  1  from adder
 rsp_valid  out  1  response valid
 rsp_ready  in  1  response accepted
 rsp_id  out  1  requester that owns the response
 rsp_result  out  DATA_WIDTH  captured add_result
 rsp_carry_out  out  1  captured add_carry_out

Function
REQ-005 FSM states: IDLE, WAIT, RESP; one operation outstanding at a time.
REQ-006 IDLE: if any reqN_valid, winner's reqN_ready=1 combinationally (same cycle); the other ready=0; next state WAIT.
REQ-007 reqN_ready SHALL be 0 in WAIT and RESP.
REQ-008 Arbitration: single valid wins; both valid -> requester != last_grant wins; last_grant updates on every handshake.
REQ-009 On handshake edge, winner's op_a/op_b/carry_in SHALL register onto add_op_a/add_op_b/add_carry_in, and rsp_id SHALL load winner index; add_* held constant until next handshake.
REQ-010 Latency counter loads ADDER_LATENCY at handshake; decrements each WAIT cycle; when 0 in WAIT, add_result/add_carry_out captured into rsp_result/rsp_carry_out, state -> RESP.
REQ-011 rsp_valid rises exactly ADDER_LATENCY+1 cycles after handshake cycle (ADDER_LATENCY=0: next cycle).
REQ-012 RESP: rsp_valid=1; rsp_* stable until rsp_valid&&rsp_ready; then -> IDLE, rsp_valid=0 next cycle.
REQ-013 No new request accepted in the cycle of the response handshake; earliest next reqN_ready is the following cycle.
REQ-014 reqN_valid deasserting during WAIT/RESP SHALL have no effect on the outstanding operation.

Reset
REQ-015 During reset: state IDLE, counter 0, last_grant=1 (req0 wins first contention), all outputs 0.
REQ-016 Reset mid-operation SHALL discard the operation; no rsp_valid issued after release.
REQ-017 First acceptance possible in first cycle after reset_n deasserts.

Configuration
REQ-018 Macro DADDER_DP_ARB_LOCK_EN: when defined, add inputs req0_lock, req1_lock (1 bit); if lock=1 at a handshake, that requester wins the next arbitration whenever it is valid, regardless of round-robin; lock released when a handshake occurs with lock=0.
REQ-019 Without DADDER_DP_ARB_LOCK_EN: lock ports absent; pure round-robin per REQ-008.

Verification
REQ-020 req0 only, op_a=0x00000999, op_b=0x00000001, cin=0, model result 0x00001000 -> req0_ready in cycle 0, rsp_valid cycle 2 (LATENCY=1), rsp_id=0, rsp_result=0x00001000.
REQ-021 Both valid every cycle, 4 operations -> grant order 0,1,0,1; rsp_id matches.
REQ-022 rsp_ready held 0 for 5 cycles in RESP -> rsp_* stable, reqN_ready=0 throughout; release -> IDLE next cycle.
REQ-023 reset_n asserted 1 cycle after handshake -> no rsp_valid; next contention grants req0.
REQ-024 ADDER_LATENCY=0 and =3 -> rsp_valid 1 and 4 cycles after handshake respectively.
REQ-025 LOCK_EN, req0_lock=1, both valid, 3 ops -> all granted to req0; req0_lock=0 on third -> fourth grant to req1.
